pong_paddle_input: RTL

PONG_PADDLE_INPUT -- requirements
Module: pong_paddle_input

---
 rtl/pong_paddle_input.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pong_paddle_input.sv
// rtl/pong_paddle_input.sv - synchronized, debounced quadrature paddles and start button
module pong_paddle_input #(
    parameter int POS_W    = 8,
    parameter int POS_MAX  = 200,
    parameter int POS_INIT = 100,
    parameter int STEP     = 4,
    parameter int DB_COUNT = 1000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             enc1_a,
    input  logic             enc1_b,
    input  logic             enc2_a,
    input  logic             enc2_b,
    input  logic             btn_start,
    input  logic             active,
    output logic [POS_W-1:0] paddle1_pos,
    output logic [POS_W-1:0] paddle2_pos,
    output logic             start_pulse
);

    localparam int              CNT_W    = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam int              N_IN     = 5;

    logic             rst_meta_q, rst_sync_q;
    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  sync1_q, sync2_q;
    logic [N_IN-1:0]  db_q, db_d, db_prev_q;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic [POS_W-1:0] pos1_q, pos1_d, pos2_q, pos2_d;
    logic             start_q, start_d;
    logic [1:0]       dir1, dir2;

    // Assert asynchronously, release two clocks after wb_rst_n rises.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign raw = {btn_start, enc2_b, enc2_a, enc1_b, enc1_a};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b01:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    // Difference of positions on the 4-state cycle: 1 = forward, 3 = backward, 0/2 = no move.
    assign dir1 = gray_idx({db_q[0], db_q[1]}) - gray_idx({db_prev_q[0], db_prev_q[1]});
    assign dir2 = gray_idx({db_q[2], db_q[3]}) - gray_idx({db_prev_q[2], db_prev_q[3]});

    function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos,
                                                  input logic [1:0]       dir);
        logic [POS_W:0] sum;
        sum = {1'b0, pos} + (POS_W+1)'(STEP);
        if (dir == 2'd1) begin
            next_pos = (sum > (POS_W+1)'(POS_MAX)) ? POS_W'(POS_MAX) : sum[POS_W-1:0];
        end else if (dir == 2'd3) begin
            next_pos = (pos >= POS_W'(STEP)) ? pos - POS_W'(STEP) : '0;
        end else begin
            next_pos = pos;
        end
    endfunction

    always_comb begin
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        start_d = 1'b0;
        if (active) begin
            pos1_d  = next_pos(pos1_q, dir1);
            pos2_d  = next_pos(pos2_q, dir2);
            start_d = db_q[4] & ~db_prev_q[4];
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
            pos1_q    <= POS_W'(POS_INIT);
            pos2_q    <= POS_W'(POS_INIT);
            start_q   <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
            pos1_q    <= pos1_d;
            pos2_q    <= pos2_d;
            start_q   <= start_d;
        end
    end

    assign paddle1_pos = pos1_q;
    assign paddle2_pos = pos2_q;
    assign start_pulse = start_q;

endmodule
